// File: rtl/uart_boot_loader.sv
// Boot loader: turns the UART RX byte stream (header N, then N little-endian words)
// into imem writes and releases the core afterwards. Optional macro: BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic [ADDR_W:0]   loaded_words,
  output logic              load_err
);

  typedef enum logic [2:0] {HDR, LOAD, CHK, RUN, ERR} state_t;

  localparam logic [32:0] DEPTH_L = 33'd1 << ADDR_W;

  state_t        state, state_next;
  logic [1:0]    byte_idx;
  logic [31:0]   asm_word;
  logic [31:0]   word_next;
  logic [ADDR_W:0] n_words;
  logic          byte_take;
  logic          word_done;
  logic          last_wr;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // Current byte dropped into its little-endian lane of the word being assembled.
  always_comb begin
    word_next = asm_word;
    case (byte_idx)
      2'd0: word_next[7:0]   = rx_data;
      2'd1: word_next[15:8]  = rx_data;
      2'd2: word_next[23:16] = rx_data;
      default: word_next[31:24] = rx_data;
    endcase
  end

  // During the final write cycle a new byte belongs to the checksum (or is ignored), not a word.
  assign last_wr   = imem_we && (loaded_words == n_words);
  assign byte_take = rx_valid && ((state == HDR) || ((state == LOAD) && !last_wr));
  assign word_done = byte_take && (byte_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (word_done) begin
          if (word_next == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
            state_next = CHK;
`else
            state_next = RUN;
`endif
          end else if ({1'b0, word_next} > DEPTH_L) begin
            state_next = ERR;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (last_wr) begin
`ifdef BOOT_CHECKSUM_EN
          if (rx_valid) state_next = (rx_data == csum) ? RUN : ERR;
          else          state_next = CHK;
`else
          state_next = RUN;
`endif
        end
      end
      CHK: begin
`ifdef BOOT_CHECKSUM_EN
        if (rx_valid) state_next = (rx_data == csum) ? RUN : ERR;
`else
        state_next = ERR;
`endif
      end
      RUN:     state_next = RUN;
      ERR:     state_next = ERR;
      default: state_next = HDR;
    endcase
  end

  always_comb begin
    core_run = (state == RUN);
    load_err = (state == ERR);
  end

  // Byte assembly, header capture and the one-cycle-delayed imem write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx     <= 2'd0;
      asm_word     <= 32'd0;
      n_words      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      loaded_words <= '0;
    end else begin
      imem_we <= 1'b0;
      if (byte_take) begin
        asm_word <= word_next;
        byte_idx <= byte_idx + 2'd1;
      end
      if ((state == HDR) && word_done) begin
        n_words <= word_next[ADDR_W:0];
      end
      if ((state == LOAD) && word_done) begin
        imem_wdata   <= word_next;
        imem_we      <= 1'b1;
        loaded_words <= loaded_words + (ADDR_W+1)'(1);
      end
      if (imem_we) begin
        imem_addr <= imem_addr + ADDR_W'(1);
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  // Running XOR over payload bytes only; the header never reaches LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          csum <= 8'd0;
    else if ((state == LOAD) && byte_take) csum <= csum ^ rx_data;
  end
`endif

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sequences core start-up: takes the byte stream from the UART receiver (rxd path) and writes it as 32-bit words into the core's instruction memory.
- Holds the core halted until the whole program is loaded, then releases it.
- Sits between the UART RX deserializer and the core/imem write port, in the core clock domain.
- Provides a loaded-word count for the 7-segment display.

Parameters:
- ADDR_W, 10, imem word-address width; capacity DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- imem_we  out  1  imem write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address for write
- imem_wdata  out  32  word to write
- core_run  out  1  1 = core released from halt
- loaded_words  out  ADDR_W+1  words written so far
- load_err  out  1  sticky load error

Behaviour:
- Reset (async, rst_n=0): state HDR; all outputs 0; byte index, word count N, address and assembly register cleared.
- Reset mid-operation behaves identically: the core is re-halted (core_run=0) and the load restarts at HDR.
- Byte acceptance: a byte is accepted on a rising clk edge with rx_valid=1. Every accepted byte is consumed in the current state; none are dropped. There is no backpressure.
- Byte order: little-endian, the first byte goes to bits [7:0]. A 2-bit byte index wraps 3->0 after each word.
- HDR state:
  - Collects 4 bytes into the 32-bit word count N.
  - On the 4th byte's edge:
    - N==0 -> RUN.
    - N>DEPTH -> ERR.
    - else -> LOAD.
  - N is an unsigned 32-bit compare; no truncation before the compare.
- LOAD state:
  - Assembles bytes into a word.
  - On the 4th byte's edge, registers the word. imem_we=1 in the following cycle, with imem_addr = current address and imem_wdata = the word.
  - Address increments after each write; loaded_words increments in the same cycle as imem_we.
  - The cycle after the write of word N-1 (last word): go to RUN (or CHK when the option is enabled).
  - A byte arriving in the same cycle as imem_we is accepted normally as byte 0 of the next word.
- RUN state: core_run=1 and held. All further rx bytes are ignored. No writes occur. Exit only by reset.
- ERR state: load_err=1, core_run=0, rx ignored. Exit only by reset.
- Write latency: exactly 1 cycle from the edge accepting the final byte of a word to imem_we high.
- Release latency: core_run rises 1 cycle after the last imem_we (N>0), or 1 cycle after the header completes (N==0).
- imem_we never asserts outside LOAD. imem_addr never exceeds DEPTH-1.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - A CHK state follows LOAD. It expects 1 trailing byte equal to the XOR of all payload bytes (header excluded).
  - Match -> RUN on that byte's edge. Mismatch -> ERR.
  - For N==0, CHK is still entered and the expected byte is 0x00.
- Undefined: no CHK state; LOAD goes directly to RUN; no trailing byte is expected. Any extra byte is ignored in RUN.

Test Plan:
- Header 02 00 00 00, payload 78 56 34 12 EF BE AD DE -> imem_we twice:
  - addr0 = 0x12345678, addr1 = 0xDEADBEEF.
  - loaded_words = 2.
  - core_run=1 one cycle after the 2nd write.
- Header 00 00 00 00 -> no imem_we; core_run=1 the cycle after the 4th header byte.
- Header with N = DEPTH+1 (ADDR_W=10: 01 04 00 00) -> load_err=1, core_run=0, no writes. Subsequent bytes ignored.
- rst_n pulsed low after 5 payload bytes of N=3 -> outputs cleared. A fresh N=1 load then writes addr0 correctly and releases the core.
- Back-to-back rx_valid every cycle for N=4 -> 4 writes at addresses 0..3, none missed. Bytes after RUN produce no imem_we.
- BOOT_CHECKSUM_EN, N=1, payload 01 02 04 08:
  - trailing 0x0F -> RUN.
  - trailing 0x0E -> load_err=1.
